// File: rtl/uart_rx_frame_counter_if.sv
// Control and status bundle between the RX start detector and the edge/bit counter.
// master drives configuration and restart; slave (the counter) returns positions and strobes.
interface uart_rx_frame_counter_if #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
);
    logic [PRESCALE_W-1:0] Cnt_prescale;
    logic [BIT_CNT_W-1:0]  Cnt_frame_len;
    logic                  Cnt_enable;
    logic                  Cnt_restart;
    logic [PRESCALE_W-1:0] Cnt_edge_cnt;
    logic [BIT_CNT_W-1:0]  Cnt_bit_cnt;
    logic                  Cnt_busy;
    logic                  Cnt_edge_finish;
    logic                  Cnt_sample_strobe;
    logic                  Cnt_sample_last;
    logic                  Cnt_frame_done;

    modport master (
        output Cnt_prescale, Cnt_frame_len, Cnt_enable, Cnt_restart,
        input  Cnt_edge_cnt, Cnt_bit_cnt, Cnt_busy, Cnt_edge_finish,
               Cnt_sample_strobe, Cnt_sample_last, Cnt_frame_done
    );

    modport slave (
        input  Cnt_prescale, Cnt_frame_len, Cnt_enable, Cnt_restart,
        output Cnt_edge_cnt, Cnt_bit_cnt, Cnt_busy, Cnt_edge_finish,
               Cnt_sample_strobe, Cnt_sample_last, Cnt_frame_done
    );
endinterface

// File: rtl/uart_rx_frame_counter.sv
// UART RX oversampling edge/bit counter with IDLE/RUN control; restart -> busy, edge 0 one clock later.
// No backpressure: free-runs once in RUN. CNT_CONFIG_LATCH_EN latches prescale/frame length on restart.
module uart_rx_frame_counter #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                    Cnt_CLK,
    input  logic                    Cnt_RST,
    uart_rx_frame_counter_if.slave  cnt
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(4);
    localparam logic [BIT_CNT_W-1:0]  L_MIN = BIT_CNT_W'(1);

    state_t                state;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  frame_done;

    logic [PRESCALE_W-1:0] p_live, p_eff, p_last, mid, mid_lo, mid_hi;
    logic [BIT_CNT_W-1:0]  l_live, l_eff, l_last;
    logic                  run, start, edge_finish, frame_end;

    assign p_live = (cnt.Cnt_prescale  < P_MIN) ? P_MIN : cnt.Cnt_prescale;
    assign l_live = (cnt.Cnt_frame_len < L_MIN) ? L_MIN : cnt.Cnt_frame_len;
    assign start  = cnt.Cnt_enable & cnt.Cnt_restart;

`ifdef CNT_CONFIG_LATCH_EN
    logic [PRESCALE_W-1:0] p_reg;
    logic [BIT_CNT_W-1:0]  l_reg;

    always_ff @(posedge Cnt_CLK or posedge Cnt_RST) begin
        if (Cnt_RST) begin
            p_reg <= P_MIN;
            l_reg <= L_MIN;
        end else if (start) begin
            p_reg <= p_live;
            l_reg <= l_live;
        end
    end

    assign p_eff = p_reg;
    assign l_eff = l_reg;
`else
    assign p_eff = p_live;
    assign l_eff = l_live;
`endif

    assign p_last = p_eff - PRESCALE_W'(1);
    assign l_last = l_eff - BIT_CNT_W'(1);
    assign mid    = p_eff >> 1;
    assign mid_lo = mid - PRESCALE_W'(1);
    assign mid_hi = mid + PRESCALE_W'(1);
    assign run    = (state == RUN);

    // >= rather than == so a live shrink of P or L below the current count still wraps/ends cleanly.
    assign edge_finish = run && (edge_cnt >= p_last);
    assign frame_end   = edge_finish && (bit_cnt >= l_last);

    always_ff @(posedge Cnt_CLK or posedge Cnt_RST) begin
        if (Cnt_RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!cnt.Cnt_enable) begin
                state    <= IDLE;
                edge_cnt <= '0;
                bit_cnt  <= '0;
            end else if (start) begin
                // restart beats a coinciding frame end, so no done pulse in that case
                state    <= RUN;
                edge_cnt <= '0;
                bit_cnt  <= '0;
            end else if (run) begin
                if (frame_end) begin
                    state      <= IDLE;
                    edge_cnt   <= '0;
                    bit_cnt    <= '0;
                    frame_done <= 1'b1;
                end else if (edge_finish) begin
                    edge_cnt <= '0;
                    bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                end else begin
                    edge_cnt <= edge_cnt + PRESCALE_W'(1);
                end
            end
        end
    end

    assign cnt.Cnt_edge_cnt      = edge_cnt;
    assign cnt.Cnt_bit_cnt       = bit_cnt;
    assign cnt.Cnt_busy          = run;
    assign cnt.Cnt_edge_finish   = edge_finish;
    assign cnt.Cnt_sample_strobe = run && ((edge_cnt == mid_lo) || (edge_cnt == mid) || (edge_cnt == mid_hi));
    assign cnt.Cnt_sample_last   = run && (edge_cnt == mid_hi);
    assign cnt.Cnt_frame_done    = frame_done;
endmodule

// File: tb/tb_uart_rx_frame_counter.sv
// Directed bench: frame_done pulses are scoreboarded by expected cycle; positions/strobes checked inline.
module tb_uart_rx_frame_counter;
    localparam int PW = 6;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_frame_counter_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) cnt_if ();

    uart_rx_frame_counter #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
        .Cnt_CLK (clk),
        .Cnt_RST (rst),
        .cnt     (cnt_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int exp_done_q[$];

    // Monitor: every frame_done pulse must match the next expected cycle and show an idle counter.
    always @(negedge clk) begin
        int e;
        if (cnt_if.Cnt_frame_done === 1'b1) begin
            checks++;
            if (exp_done_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected at cycle %0d (no pulse expected)", cyc);
            end else begin
                e = exp_done_q.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL done_cycle got %0d exp %0d", cyc, e);
                end
            end
            checks++;
            if (cnt_if.Cnt_busy !== 1'b0 || cnt_if.Cnt_edge_cnt !== '0 || cnt_if.Cnt_bit_cnt !== '0) begin
                errors++;
                $display("FAIL done_idle busy=%0b edge=%0d bit=%0d exp 0/0/0",
                         cnt_if.Cnt_busy, cnt_if.Cnt_edge_cnt, cnt_if.Cnt_bit_cnt);
            end
        end
    end

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic pulse_restart();
        cnt_if.Cnt_restart = 1'b1;
        tick(1);
        cnt_if.Cnt_restart = 1'b0;
    endtask

    int t;
    int t2;

    initial begin
        cnt_if.Cnt_prescale  = 6'd8;
        cnt_if.Cnt_frame_len = 4'd10;
        cnt_if.Cnt_enable    = 1'b1;
        cnt_if.Cnt_restart   = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("reset_busy", 32'(cnt_if.Cnt_busy), 0);
        chk("reset_edge", 32'(cnt_if.Cnt_edge_cnt), 0);
        chk("reset_bit", 32'(cnt_if.Cnt_bit_cnt), 0);
        chk("reset_done", 32'(cnt_if.Cnt_frame_done), 0);
        chk("reset_strobe", 32'(cnt_if.Cnt_sample_strobe), 0);

        // P=8, L=10: full frame of 80 RUN cycles
        pulse_restart();
        t = cyc;
        exp_done_q.push_back(t + 80);
        for (int i = 0; i < 8; i++) begin
            chk("p8_busy", 32'(cnt_if.Cnt_busy), 1);
            chk("p8_edge", 32'(cnt_if.Cnt_edge_cnt), 32'(i));
            chk("p8_strobe", 32'(cnt_if.Cnt_sample_strobe), 32'(i >= 3 && i <= 5));
            chk("p8_last", 32'(cnt_if.Cnt_sample_last), 32'(i == 5));
            chk("p8_finish", 32'(cnt_if.Cnt_edge_finish), 32'(i == 7));
            tick(1);
        end
        chk("p8_bit1", 32'(cnt_if.Cnt_bit_cnt), 1);
        chk("p8_edge_wrap", 32'(cnt_if.Cnt_edge_cnt), 0);
        tick(t + 79 - cyc);
        chk("p8_last_bit", 32'(cnt_if.Cnt_bit_cnt), 9);
        chk("p8_last_edge", 32'(cnt_if.Cnt_edge_cnt), 7);
        tick(1);
        chk("p8_busy_low", 32'(cnt_if.Cnt_busy), 0);
        tick(3);

        // Clamp: prescale 2 -> 4, frame_len 0 -> 1
        cnt_if.Cnt_prescale  = 6'd2;
        cnt_if.Cnt_frame_len = 4'd0;
        pulse_restart();
        t = cyc;
        exp_done_q.push_back(t + 4);
        for (int i = 0; i < 4; i++) begin
            chk("clamp_edge", 32'(cnt_if.Cnt_edge_cnt), 32'(i));
            chk("clamp_strobe", 32'(cnt_if.Cnt_sample_strobe), 32'(i >= 1));
            chk("clamp_last", 32'(cnt_if.Cnt_sample_last), 32'(i == 3));
            chk("clamp_finish", 32'(cnt_if.Cnt_edge_finish), 32'(i == 3));
            tick(1);
        end
        chk("clamp_busy_low", 32'(cnt_if.Cnt_busy), 0);
        tick(3);

        // Mid-frame restart at bit 3 edge 5, P=16
        cnt_if.Cnt_prescale  = 6'd16;
        cnt_if.Cnt_frame_len = 4'd10;
        pulse_restart();
        t = cyc;
        tick(t + 53 - cyc);
        chk("mid_bit_pre", 32'(cnt_if.Cnt_bit_cnt), 3);
        chk("mid_edge_pre", 32'(cnt_if.Cnt_edge_cnt), 5);
        pulse_restart();
        t2 = cyc;
        chk("mid_busy", 32'(cnt_if.Cnt_busy), 1);
        chk("mid_edge0", 32'(cnt_if.Cnt_edge_cnt), 0);
        chk("mid_bit0", 32'(cnt_if.Cnt_bit_cnt), 0);
        exp_done_q.push_back(t2 + 160);
        tick(t2 + 161 - cyc);
        chk("mid_busy_low", 32'(cnt_if.Cnt_busy), 0);

        // Restart coincident with frame end, P=4 L=2
        cnt_if.Cnt_prescale  = 6'd4;
        cnt_if.Cnt_frame_len = 4'd2;
        pulse_restart();
        t = cyc;
        tick(t + 7 - cyc);
        chk("coin_finish", 32'(cnt_if.Cnt_edge_finish), 1);
        chk("coin_bit", 32'(cnt_if.Cnt_bit_cnt), 1);
        pulse_restart();
        t2 = cyc;
        chk("coin_busy", 32'(cnt_if.Cnt_busy), 1);
        chk("coin_edge0", 32'(cnt_if.Cnt_edge_cnt), 0);
        chk("coin_bit0", 32'(cnt_if.Cnt_bit_cnt), 0);
        exp_done_q.push_back(t2 + 8);
        tick(t2 + 9 - cyc);
        chk("coin_busy_low", 32'(cnt_if.Cnt_busy), 0);

        // Enable dropped at bit 2 together with a restart: enable wins
        cnt_if.Cnt_prescale  = 6'd8;
        cnt_if.Cnt_frame_len = 4'd10;
        pulse_restart();
        t = cyc;
        tick(t + 19 - cyc);
        chk("en_bit2", 32'(cnt_if.Cnt_bit_cnt), 2);
        cnt_if.Cnt_enable  = 1'b0;
        cnt_if.Cnt_restart = 1'b1;
        tick(1);
        chk("en_busy", 32'(cnt_if.Cnt_busy), 0);
        chk("en_edge", 32'(cnt_if.Cnt_edge_cnt), 0);
        chk("en_bit", 32'(cnt_if.Cnt_bit_cnt), 0);
        cnt_if.Cnt_restart = 1'b0;
        cnt_if.Cnt_enable  = 1'b1;
        tick(3);
        chk("en_stay_idle", 32'(cnt_if.Cnt_busy), 0);

        // Prescale 8 -> 16 during bit 1
        pulse_restart();
        t = cyc;
        tick(t + 10 - cyc);
        cnt_if.Cnt_prescale = 6'd16;
        tick(t + 15 - cyc);
        chk("pchg_edge7", 32'(cnt_if.Cnt_edge_cnt), 7);
`ifdef CNT_CONFIG_LATCH_EN
        chk("pchg_finish7", 32'(cnt_if.Cnt_edge_finish), 1);
        exp_done_q.push_back(t + 80);
        tick(t + 81 - cyc);
        chk("pchg_busy_low", 32'(cnt_if.Cnt_busy), 0);
        pulse_restart();
        t = cyc;
        tick(t + 7 - cyc);
        chk("pchg_new_p_no_finish7", 32'(cnt_if.Cnt_edge_finish), 0);
        tick(t + 15 - cyc);
        chk("pchg_new_p_finish15", 32'(cnt_if.Cnt_edge_finish), 1);
`else
        chk("pchg_finish7", 32'(cnt_if.Cnt_edge_finish), 0);
        tick(t + 23 - cyc);
        chk("pchg_edge15", 32'(cnt_if.Cnt_edge_cnt), 15);
        chk("pchg_finish15", 32'(cnt_if.Cnt_edge_finish), 1);
        chk("pchg_bit1", 32'(cnt_if.Cnt_bit_cnt), 1);
        exp_done_q.push_back(t + 152);
        tick(t + 153 - cyc);
        chk("pchg_busy_low", 32'(cnt_if.Cnt_busy), 0);
`endif
        cnt_if.Cnt_enable = 1'b0;
        tick(1);
        cnt_if.Cnt_enable = 1'b1;
        cnt_if.Cnt_prescale = 6'd8;

        // Asynchronous reset mid-frame; no pulse may follow release
        pulse_restart();
        tick(20);
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(cnt_if.Cnt_busy), 0);
        chk("arst_edge", 32'(cnt_if.Cnt_edge_cnt), 0);
        chk("arst_bit", 32'(cnt_if.Cnt_bit_cnt), 0);
        tick(2);
        rst = 1'b0;
        tick(100);
        chk("arst_stay_idle", 32'(cnt_if.Cnt_busy), 0);

        checks++;
        if (exp_done_q.size() != 0) begin
            errors++;
            $display("FAIL done_missing got %0d pending exp 0", exp_done_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_counter.md
Name:
uart_rx_frame_counter

Overview:
- Parametrised successor to the UART receiver edge/bit counter.
- Generates per-bit oversampling edge counts, three majority-vote sample strobes around mid-bit, and frame bit counts for a programmable frame length.
- Includes a small IDLE/RUN controller and a registered frame-done pulse.
- Sits between the start-bit detector and the sampler/deserializer in the UART RX path.

Parameters:
PRESCALE_W, 6, width of prescale input and edge counter (oversampling ratio up to 2^PRESCALE_W-1)
BIT_CNT_W, 4, width of frame-length input and bit counter (frames up to 2^BIT_CNT_W-1 bits)

Ports:
Cnt_CLK  input  1  clock, rising edge
Cnt_RST  input  1  asynchronous reset, active-high
Cnt_prescale  input  PRESCALE_W  clocks per bit; effective value P = max(Cnt_prescale, 4)
Cnt_frame_len  input  BIT_CNT_W  bits per frame incl. start/parity/stop; effective value L = max(Cnt_frame_len, 1)
Cnt_enable  input  1  run permission; low forces IDLE
Cnt_restart  input  1  start-of-frame pulse from the start detector
Cnt_edge_cnt  output  PRESCALE_W  edge position within current bit, 0..P-1
Cnt_bit_cnt  output  BIT_CNT_W  bit index within frame, 0..L-1
Cnt_busy  output  1  high while in RUN
Cnt_edge_finish  output  1  last edge of current bit
Cnt_sample_strobe  output  1  sample-point strobe, 3 per bit
Cnt_sample_last  output  1  third (final) sample point of the bit
Cnt_frame_done  output  1  registered one-cycle pulse after a frame completes

Behaviour:
- Reset (Cnt_RST=1, async): state IDLE; Cnt_edge_cnt=0, Cnt_bit_cnt=0, Cnt_busy=0, Cnt_frame_done=0. All combinational strobes are 0 because they are gated by RUN.
- States:
  - IDLE: counters held at 0.
  - RUN: counters advance.
- Transitions:
  - IDLE->RUN when Cnt_restart=1 and Cnt_enable=1.
  - RUN->IDLE on frame end, or when Cnt_enable=0.
- Latency: restart sampled at edge t gives Cnt_busy=1 and Cnt_edge_cnt=0 after edge t. The edge counter then increments by 1 every clock.
- Edge counter: wraps P-1 -> 0 (exactly P clocks per bit). Cnt_edge_finish = RUN and edge_cnt==P-1, combinational.
- Bit counter: increments when Cnt_edge_finish=1, otherwise holds.
- Frame end: Cnt_edge_finish=1 and bit_cnt==L-1.
  - Next state is IDLE with both counters 0.
  - Cnt_frame_done=1 for exactly the following cycle.
- Sample points: M = P>>1. Cnt_sample_strobe=1 in RUN when edge_cnt is M-1, M or M+1. Cnt_sample_last=1 only at M+1. All strobes are combinational from registered counters.
- Width rules:
  - Comparisons use P-1 and M+1 computed at PRESCALE_W bits. No overflow is possible since P>=4 and M+1<=P-1.
  - Bit counter never exceeds L-1.
- Restart in RUN (mid-frame): both counters go to 0, state stays RUN, no frame_done pulse.
- Restart in the same cycle as frame end: restart wins; state stays RUN, counters 0, no frame_done pulse.
- Enable low in RUN: go to IDLE, counters 0, no frame_done. Enable low takes priority over restart.
- Prescale/frame_len changing during RUN: the new value applies from the next cycle (live), unless the optional feature is enabled.
- Cnt_RST asserted mid-frame: immediate return to reset values; no pulse after release.

Optional Feature:
- Macro: CNT_CONFIG_LATCH_EN.
- Defined: P and L are captured into internal registers on every accepted restart. Registers reset to P=4, L=1. Input changes during RUN have no effect until the next restart.
- Undefined: Cnt_prescale/Cnt_frame_len are used live every cycle, with no extra registers.

Test Plan:
- Reset: assert Cnt_RST mid-count -> all outputs 0 asynchronously; no frame_done after release.
- P=8, L=10, enable=1, one restart pulse:
  - edge_cnt sequence 0..7 repeating; sample_strobe at edges 3,4,5; sample_last at 5.
  - bit_cnt 0..9; frame_done high exactly 80 cycles after busy rises, busy low the same cycle.
- Clamp: Cnt_prescale=2, frame_len=0 -> P=4, L=1 behaviour; edge_finish at edge 3; strobes at 1,2,3; frame_done after 4 RUN cycles.
- Mid-frame restart at bit 3 edge 5 (P=16) -> counters 0 next cycle, busy stays 1; no frame_done until a full new frame completes.
- Restart coincident with frame end, and enable dropped at bit 2 -> no frame_done in either case; first case stays RUN, second goes IDLE with counters 0.
- Prescale changed 8->16 at bit 1:
  - Without CNT_CONFIG_LATCH_EN: edge_finish moves to edge 15 next cycle.
  - With CNT_CONFIG_LATCH_EN: edge_finish stays at edge 7 until the next restart.
